// File: rtl/router_inport.sv
// Router inbound port: reassembles the node's LSB-first byte stream into packets
// and queues whole packets for the router core behind an available/clear handshake.
module router_inport #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned NBYTES = 4
) (
  input  logic                               clk,
  input  logic                               rst_b,
  input  logic                               put_inbound,
  input  logic [7:0]                         payload_inbound,
  output logic                               free_inbound,
  output logic                               data_available,
  output logic [8*NBYTES-1:0]                data_from_node,
  input  logic                               clear_data_available,
  output logic                               protocol_err,
  output logic [$clog2(DEPTH+1)-1:0]         pkt_count
);

  localparam int unsigned PW   = 8 * NBYTES;
  localparam int unsigned CW   = $clog2(DEPTH + 1);
  localparam int unsigned BW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {ST_IDLE, ST_RECV} state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [PW-1:0]     asm_q, asm_d;
  logic [PW-1:0]     mem_q [DEPTH];
  logic [PTRW-1:0]   head_q, head_d;
  logic [PTRW-1:0]   tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              free_q, free_d;
  logic              err_q, err_d;
  logic              push_c;
  logic              pop_c;

  // Byte assembly FSM; a packet commits on the edge carrying its last byte.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    push_c  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (put_inbound) begin
          if (free_q) begin
            asm_d   = PW'(payload_inbound);
            bcnt_d  = BW'(1);
            state_d = ST_RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (put_inbound) begin
          for (int unsigned k = 0; k < NBYTES; k++) begin
            if (bcnt_q == BW'(k)) asm_d[8*k +: 8] = payload_inbound;
          end
          if (bcnt_q == BW'(NBYTES - 1)) begin
            push_c  = 1'b1;
            bcnt_d  = '0;
            state_d = ST_IDLE;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end else begin
          // Truncated packet: drop the partial assembly.
          err_d   = 1'b1;
          bcnt_d  = '0;
          asm_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Queue pointers and occupancy; free_inbound reserves a slot for any packet in flight.
  always_comb begin
    pop_c   = clear_data_available && (count_q != '0);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(push_c) - CW'(pop_c);
    if (push_c) tail_d = (tail_q == PTRW'(DEPTH - 1)) ? '0 : tail_q + PTRW'(1);
    if (pop_c)  head_d = (head_q == PTRW'(DEPTH - 1)) ? '0 : head_q + PTRW'(1);
    free_d = (state_d == ST_IDLE) && (count_d < CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
      asm_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      free_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      free_q  <= free_d;
      err_q   <= err_d;
    end
  end

  // Packet storage needs no reset; reads are gated by count.
  always_ff @(posedge clk) begin
    if (!rst_b && push_c) begin
      mem_q[tail_q] <= asm_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b && push_c) begin
      assert (count_q < CW'(DEPTH));
    end
  end

  assign free_inbound   = free_q;
  assign protocol_err   = err_q;
  assign pkt_count      = count_q;
  assign data_available = (count_q != '0);
  assign data_from_node = (count_q != '0) ? mem_q[head_q] : '0;

endmodule

// File: doc/router_inport.md
Name: router_inport

Overview:
- Router-side inbound port for one node link.
- Accepts the 4-byte serial stream a node drives on put/payload and reassembles it into a 32-bit packet. Bytes arrive least-significant first.
- Queues whole packets in a small packet FIFO and presents the head packet to the router core with an available/clear handshake.
- Throttles the node through free_inbound so a started packet always has a slot.

Parameters:
- DEPTH, 2, number of whole packets held; legal range 1..8.
- NBYTES, 4, bytes per packet; packet width is 8*NBYTES. Fixed at 4 for this project.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_b  input  1  synchronous, active-high reset; sampled on the rising clk edge; 1 = reset.
- put_inbound  input  1  node drives a valid payload byte this cycle.
- payload_inbound  input  8  current byte; byte k of a packet goes to pkt[8k+7:8k].
- free_inbound  output  1  registered; 1 = port will accept a complete new packet starting next cycle.
- data_available  output  1  queue non-empty; data_from_node is valid.
- data_from_node  output  32  head packet; combinational read of the queue head.
- clear_data_available  input  1  router core consumed the head packet; pop on this edge.
- protocol_err  output  1  registered one-cycle pulse on a link protocol violation.
- pkt_count  output  clog2(DEPTH+1)  current queue occupancy, for debug and verification.

Behaviour:
- Reset (rst_b=1 at an edge) has priority over all other activity, including mid-packet. On reset:
  - FSM goes to IDLE; byte counter and assembly register are cleared.
  - The queue is emptied: head/tail/count = 0.
  - free_inbound=0, protocol_err=0, data_available=0, data_from_node=0, pkt_count=0.
- First cycle after reset release: free_inbound becomes 1, because the queue is empty.
- FSM states: IDLE, RECV.
- IDLE:
  - put_inbound=1 and free_inbound=1: latch byte 0, byte counter becomes 1, go to RECV.
  - put_inbound=1 and free_inbound=0: byte ignored, protocol_err pulses, stay in IDLE.
- RECV, put_inbound=1:
  - Latch byte[counter] and increment the counter.
  - When counter==NBYTES-1, the assembled packet (including the current byte) is pushed into the queue on that same edge, the counter clears, and the FSM returns to IDLE.
- RECV, put_inbound=0 before the last byte (truncated packet): discard the partial packet, pulse protocol_err, return to IDLE. The queue is unchanged.
- Back-to-back packets: put may stay high across a packet boundary only if free_inbound was 1 in the cycle the new packet's byte 0 arrives. Otherwise the IDLE error rule applies.
- free_inbound register:
  - Next value = (next_state==IDLE) && (next_count < DEPTH).
  - next_count includes this edge's push and pop.
  - It is held 0 throughout RECV, because the in-progress packet reserves a slot.
- Queue push/pop rules:
  - Push only on commit.
  - Pop when clear_data_available=1 and count>0.
  - clear_data_available=1 with count==0 is ignored: no error, nothing changes.
  - Simultaneous push and pop: count unchanged, head and tail both advance, each wrapping modulo DEPTH.
  - A push can never find the queue full, because of the free_inbound reservation. Implementation asserts this in simulation.
- data_available = (count!=0).
- data_from_node = mem[head] when count!=0, else 32'h0.
- Latency: last byte at edge N → data_available=1 and data valid in the cycle after edge N, when the queue was empty. Pop at edge M → next packet, or 0, visible after edge M.
- protocol_err is high for exactly one cycle per violation; it never sticks.

Test Plan:
- Reset then idle: hold rst_b=1 for 2 cycles, release → free_inbound=1 one cycle later; data_available=0, pkt_count=0, data_from_node=32'h0.
- Single packet: bytes 8'h11,8'h22,8'h33,8'h44 on 4 consecutive put cycles → free_inbound=0 during RECV; after the 4th edge data_from_node=32'h44332211, data_available=1; pulse clear → data_available=0, free_inbound=1.
- Fill to DEPTH=2 without clears: send 32'hA0A1A2A3 then 32'hB0B1B2B3 → after the second commit pkt_count=2 and free_inbound=0. A third put → protocol_err pulses once and pkt_count stays 2. Two clears return the packets in order A then B.
- Simultaneous push/pop: with one packet queued, assert clear on the same edge as the 4th byte of the next packet → pkt_count stays 1, head is the new packet, free_inbound=1.
- Truncated packet: put high for 2 bytes then low → protocol_err=1 for one cycle, pkt_count unchanged. A following full packet 32'hDEADBEEF is received intact.
- Reset mid-packet plus spurious clear: assert rst_b after byte 2 of a packet with one packet already queued → everything clears, free_inbound=1 after release. A clear while empty then gives no change and no error.
